// File: rtl/dram_pkg.sv
// Shared types for the DRAM request unit: controller command encodings,
// controller state, request-FSM state codes and the default address window.
package dram_pkg;

  typedef enum logic [2:0] {
    RD_NONE = 3'd0,
    RD_LB   = 3'd1,
    RD_LBU  = 3'd2,
    RD_LH   = 3'd3,
    RD_LHU  = 3'd4,
    RD_LW   = 3'd5,
    RD_LD   = 3'd6,
    RD_LWU  = 3'd7
  } rd_ctrl_e;

  typedef enum logic [2:0] {
    WR_NONE = 3'd0,
    WR_SB   = 3'd1,
    WR_SH   = 3'd2,
    WR_SW   = 3'd3,
    WR_SD   = 3'd4
  } wr_ctrl_e;

  typedef enum logic [1:0] {
    DS_IDLE  = 2'd0,
    DS_READ  = 2'd1,
    DS_WRITE = 2'd2
  } dram_state_e;

  typedef logic [2:0] req_state_t;

  localparam req_state_t ST_IDLE      = 3'd0;
  localparam req_state_t ST_ISSUE     = 3'd1;
  localparam req_state_t ST_WAIT      = 3'd2;
  localparam req_state_t ST_RMW_ISSUE = 3'd3;
  localparam req_state_t ST_RMW_WAIT  = 3'd4;
  localparam req_state_t ST_RESP      = 3'd5;

  localparam logic [63:0] DRAM_BASE_DEFAULT = 64'h8000_0000;
  localparam int          TIMEOUT_DEFAULT   = 64;

  // Natural alignment: halfword to 2, word to 4, doubleword to 8 bytes.
  function automatic logic misaligned(input logic [2:0] rd, input logic [2:0] wr,
                                      input logic [2:0] a);
    logic bad;
    bad = 1'b0;
    if (rd == RD_LH || rd == RD_LHU || wr == WR_SH)                  bad = a[0];
    else if (rd == RD_LW || rd == RD_LWU || wr == WR_SW)             bad = |a[1:0];
    else if (rd == RD_LD || wr == WR_SD)                             bad = |a;
    return bad;
  endfunction

endpackage

// File: rtl/dram_req_unit_if.sv
// Pipeline-facing request/response bundle of the DRAM request unit.
// master = pipeline MEM stage, slave = dram_req_unit.
interface dram_req_if;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_rd_ctrl;
  logic [2:0]  req_wr_ctrl;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic        resp_valid;
  logic [63:0] resp_rdata;
  logic        resp_err;
  logic        busy;

  modport master (
    output req_valid, req_rd_ctrl, req_wr_ctrl, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err, busy
  );

  modport slave (
    input  req_valid, req_rd_ctrl, req_wr_ctrl, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_err, busy
  );
endinterface

// File: rtl/dram_req_unit_load_ext.sv
// Load-data extender: selects the byte/half/word/double from the controller
// read data and sign- or zero-extends it to 64 bits.
module mem_load_ext
  import dram_pkg::*;
(
  input  logic [2:0]  i_rd_ctrl,
  input  logic        i_lane,
  input  logic [63:0] i_dout,
  output logic [63:0] o_rdata
);

  logic [7:0] w_byte;

  // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
  always_comb begin
    o_rdata = '0;
    w_byte  = i_lane ? i_dout[15:8] : i_dout[7:0];
    case (i_rd_ctrl)
      RD_LB:   o_rdata = {{56{w_byte[7]}}, w_byte};
      RD_LBU:  o_rdata = {56'h0, w_byte};
      RD_LH:   o_rdata = {{48{i_dout[15]}}, i_dout[15:0]};
      RD_LHU:  o_rdata = {48'h0, i_dout[15:0]};
      RD_LW:   o_rdata = {{32{i_dout[31]}}, i_dout[31:0]};
      RD_LWU:  o_rdata = {32'h0, i_dout[31:0]};
      RD_LD:   o_rdata = i_dout;
      default: o_rdata = '0;
    endcase
  end

endmodule

// File: rtl/dram_req_unit.sv
// MEM-stage front end for the 16-bit DRAM controller: checks, issues and
// completes one load/store at a time. DRAM_BYTE_RMW_EN makes SB a read-modify-write.
module dram_req_unit
  import dram_pkg::*;
#(
  parameter logic [63:0] DRAM_BASE      = DRAM_BASE_DEFAULT,
  parameter int          TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  dram_req_if.slave   req_if,
  output logic [2:0]  dm_rd_ctrl,
  output logic [2:0]  dm_wr_ctrl,
  output logic [63:0] dm_addr,
  output logic [63:0] dm_din,
  input  logic [63:0] dm_dout,
  input  logic [1:0]  dram_state
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  req_state_t       r_state;
  logic [2:0]       r_rd;
  logic [2:0]       r_wr;
  logic [63:0]      r_addr;
  logic [63:0]      r_wdata;
  logic             r_err;
  logic [63:0]      r_load;
  logic [CNT_W-1:0] r_cnt;

  logic        w_accept;
  logic        w_req_err;
  logic        w_dram_idle;
  logic        w_timeout;
  logic        w_is_sb;
  logic        w_rmw;
  logic        w_active;
  logic [15:0] w_merged;
  logic [63:0] w_ext;

  assign w_accept    = (r_state == ST_IDLE) && req_if.req_valid &&
                       ((req_if.req_rd_ctrl != RD_NONE) || (req_if.req_wr_ctrl != WR_NONE));
  assign w_req_err   = ((req_if.req_rd_ctrl != RD_NONE) && (req_if.req_wr_ctrl != WR_NONE)) ||
                       (req_if.req_wr_ctrl > WR_SD) ||
                       (req_if.req_addr < DRAM_BASE) ||
                       misaligned(req_if.req_rd_ctrl, req_if.req_wr_ctrl, req_if.req_addr[2:0]);
  assign w_dram_idle = (dram_state == DS_IDLE);
  assign w_timeout   = (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
  assign w_is_sb     = (r_wr == WR_SB);
`ifdef DRAM_BYTE_RMW_EN
  assign w_rmw       = w_is_sb;
`else
  assign w_rmw       = 1'b0;
`endif
  assign w_active    = (r_state == ST_ISSUE) || (r_state == ST_WAIT) ||
                       (r_state == ST_RMW_ISSUE) || (r_state == ST_RMW_WAIT);
  // The store byte replaces lane addr[0] of the halfword read back in WAIT.
  assign w_merged    = r_addr[0] ? {r_wdata[7:0], r_load[7:0]} : {r_load[15:8], r_wdata[7:0]};

  mem_load_ext u_load_ext (
    .i_rd_ctrl (r_rd),
    .i_lane    (r_addr[0]),
    .i_dout    (r_load),
    .o_rdata   (w_ext)
  );

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_rd    <= '0;
      r_wr    <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_err   <= 1'b0;
      r_load  <= '0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_rd    <= req_if.req_rd_ctrl;
            r_wr    <= req_if.req_wr_ctrl;
            r_addr  <= req_if.req_addr;
            r_wdata <= req_if.req_wdata;
            r_err   <= w_req_err;
            r_state <= w_req_err ? ST_RESP : ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (w_dram_idle) begin
            r_cnt   <= '0;
            r_state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (w_dram_idle) begin
            r_load  <= dm_dout;
            r_state <= w_rmw ? ST_RMW_ISSUE : ST_RESP;
          end else if (w_timeout) begin
            r_err   <= 1'b1;
            r_state <= ST_RESP;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        ST_RMW_ISSUE: begin
          if (w_dram_idle) begin
            r_cnt   <= '0;
            r_state <= ST_RMW_WAIT;
          end
        end
        ST_RMW_WAIT: begin
          if (w_dram_idle) begin
            r_state <= ST_RESP;
          end else if (w_timeout) begin
            r_err   <= 1'b1;
            r_state <= ST_RESP;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        ST_RESP: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // The command is a single-cycle strobe, held off while the controller is busy.
  always_comb begin
    dm_rd_ctrl = RD_NONE;
    dm_wr_ctrl = WR_NONE;
    if (w_dram_idle && (r_state == ST_ISSUE)) begin
      if (w_rmw)                 dm_rd_ctrl = RD_LHU;
      else if (r_rd == RD_LWU)   dm_rd_ctrl = RD_LW;
      else if (r_rd != RD_NONE)  dm_rd_ctrl = r_rd;
      else                       dm_wr_ctrl = r_wr;
    end else if (w_dram_idle && (r_state == ST_RMW_ISSUE)) begin
      dm_wr_ctrl = WR_SH;
    end
  end

  always_comb begin
    dm_addr = '0;
    dm_din  = '0;
    if (w_active) begin
      dm_addr = w_rmw ? {r_addr[63:1], 1'b0} : r_addr;
      if (w_rmw)                dm_din = {48'h0, w_merged};
      else if (w_is_sb)         dm_din = {48'h0, r_wdata[7:0], r_wdata[7:0]};
      else if (r_wr != WR_NONE) dm_din = r_wdata;
    end
  end

  assign req_if.req_ready  = (r_state == ST_IDLE);
  assign req_if.busy       = (r_state != ST_IDLE);
  assign req_if.resp_valid = (r_state == ST_RESP);
  assign req_if.resp_err   = (r_state == ST_RESP) && r_err;
  assign req_if.resp_rdata = ((r_state == ST_RESP) && !r_err && (r_rd != RD_NONE)) ? w_ext : '0;

endmodule

// File: tb/tb_dram_req_unit.sv
// Scoreboard bench for dram_req_unit with a byte-array DRAM controller model.
`timescale 1ns/1ps
module tb_dram_req_unit;
  import dram_pkg::*;

`ifdef DRAM_BYTE_RMW_EN
  localparam bit RMW = 1'b1;
`else
  localparam bit RMW = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dram_req_if bus ();
  logic [2:0]  dm_rd_ctrl, dm_wr_ctrl;
  logic [63:0] dm_addr, dm_din;
  logic [63:0] m_dout = '0;
  logic [1:0]  m_state = 2'b00;

  dram_req_unit dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_if     (bus.slave),
    .dm_rd_ctrl (dm_rd_ctrl),
    .dm_wr_ctrl (dm_wr_ctrl),
    .dm_addr    (dm_addr),
    .dm_din     (dm_din),
    .dm_dout    (m_dout),
    .dram_state (m_state)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // ---------------- controller model: 256-byte window, N busy beats per command
  logic [7:0] mem [0:255];
  int m_beats = 0;
  int m_left  = 0;

  function automatic logic [63:0] rd64(input logic [7:0] a);
    logic [63:0] v;
    for (int i = 0; i < 8; i++) v[8*i +: 8] = mem[a + 8'(i)];
    return v;
  endfunction

  function automatic int nbytes(input logic [2:0] w);
    case (w)
      WR_SB, WR_SH: return 2;
      WR_SW:        return 4;
      WR_SD:        return 8;
      default:      return 0;
    endcase
  endfunction

  always @(posedge clk) begin
    if (dm_rd_ctrl != 3'd0 || dm_wr_ctrl != 3'd0) begin
      if (dm_rd_ctrl != 3'd0) m_dout <= rd64({dm_addr[7:1], 1'b0});
      for (int i = 0; i < 8; i++)
        if (i < nbytes(dm_wr_ctrl))
          mem[((dm_wr_ctrl == WR_SB) ? {dm_addr[7:1], 1'b0} : dm_addr[7:0]) + 8'(i)] <= dm_din[8*i +: 8];
      m_left  <= m_beats;
      m_state <= (m_beats == 0) ? 2'b00 : ((dm_rd_ctrl != 3'd0) ? 2'b01 : 2'b10);
    end else if (m_state != 2'b00) begin
      if (m_left <= 1) m_state <= 2'b00;
      m_left <= m_left - 1;
    end
  end

  // ---------------- scoreboard and monitor
  typedef struct {
    logic [63:0] rdata;
    logic        err;
  } exp_t;
  exp_t exp_q[$];
  exp_t e;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmd = 0, n_resp = 0, t_cmd = 0, t_resp = 0, t_drive = 0;
  logic [2:0] last_rd = 3'd0;

  always @(negedge clk) begin
    if (dm_rd_ctrl != 3'd0 || dm_wr_ctrl != 3'd0) begin
      n_cmd++;
      t_cmd = cyc;
      last_rd = dm_rd_ctrl;
    end
    if (bus.resp_valid) begin
      n_resp++;
      t_resp = cyc;
      check("busy_at_resp", {63'h0, bus.busy}, 64'd1);
      if (exp_q.size() == 0) begin
        check("unexpected_resp", {63'h0, bus.resp_valid}, 64'd0);
      end else begin
        e = exp_q.pop_front();
        check("rdata", bus.resp_rdata, e.rdata);
        check("err", {63'h0, bus.resp_err}, {63'h0, e.err});
      end
    end
  end

  // ---------------- driver
  task automatic do_req(input logic [2:0] rd, input logic [2:0] wr, input logic [63:0] addr,
                        input logic [63:0] wdata, input logic [63:0] exp_rdata,
                        input logic exp_err, input bit push);
    int guard = 0;
    @(negedge clk);
    while (!bus.req_ready && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    if (!bus.req_ready) check("ready_timeout", {63'h0, bus.req_ready}, 64'd1);
    if (push) exp_q.push_back('{exp_rdata, exp_err});
    bus.req_valid   = 1'b1;
    bus.req_rd_ctrl = rd;
    bus.req_wr_ctrl = wr;
    bus.req_addr    = addr;
    bus.req_wdata   = wdata;
    t_drive = cyc;
    @(negedge clk);
    bus.req_valid   = 1'b0;
    bus.req_rd_ctrl = 3'd0;
    bus.req_wr_ctrl = 3'd0;
  endtask

  task automatic drain();
    int guard = 0;
    while (exp_q.size() != 0 && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    check("resp_timeout", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic req(input logic [2:0] rd, input logic [2:0] wr, input logic [63:0] addr,
                     input logic [63:0] wdata, input logic [63:0] exp_rdata, input logic exp_err);
    do_req(rd, wr, addr, wdata, exp_rdata, exp_err, 1'b1);
    drain();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int c0, r0, guard;
    bus.req_valid   = 1'b0;
    bus.req_rd_ctrl = 3'd0;
    bus.req_wr_ctrl = 3'd0;
    bus.req_addr    = '0;
    bus.req_wdata   = '0;

    // reset state
    #12;
    check("rst_ready", {63'h0, bus.req_ready}, 64'd1);
    check("rst_busy", {63'h0, bus.busy}, 64'd0);
    check("rst_resp_valid", {63'h0, bus.resp_valid}, 64'd0);
    check("rst_dm_rd", {61'h0, dm_rd_ctrl}, 64'd0);
    check("rst_dm_addr", dm_addr, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // preload through the unit with doubleword stores
    m_beats = 1;
    req(3'd0, WR_SD, 64'h8000_0010, 64'h1122_3344_5566_7788, 64'd0, 1'b0);
    req(3'd0, WR_SD, 64'h8000_0000, 64'h0000_0000_80AB_1234, 64'd0, 1'b0);
    req(3'd0, WR_SD, 64'h8000_0020, 64'h0000_0000_9ABC_DEF0, 64'd0, 1'b0);

    // LD: data, exactly one response and one command
    m_beats = 3;
    c0 = n_cmd; r0 = n_resp;
    req(RD_LD, 3'd0, 64'h8000_0010, 64'd0, 64'h1122_3344_5566_7788, 1'b0);
    repeat (5) @(negedge clk);
    check("ld_one_resp", 64'(n_resp - r0), 64'd1);
    check("ld_one_cmd", 64'(n_cmd - c0), 64'd1);

    // extension: byte lanes, halves, words
    req(RD_LB,  3'd0, 64'h8000_0003, 64'd0, 64'hFFFF_FFFF_FFFF_FF80, 1'b0);
    req(RD_LBU, 3'd0, 64'h8000_0003, 64'd0, 64'h0000_0000_0000_0080, 1'b0);
    req(RD_LB,  3'd0, 64'h8000_0002, 64'd0, 64'hFFFF_FFFF_FFFF_FFAB, 1'b0);
    req(RD_LH,  3'd0, 64'h8000_0002, 64'd0, 64'hFFFF_FFFF_FFFF_80AB, 1'b0);
    req(RD_LHU, 3'd0, 64'h8000_0002, 64'd0, 64'h0000_0000_0000_80AB, 1'b0);
    req(RD_LW,  3'd0, 64'h8000_0020, 64'd0, 64'hFFFF_FFFF_9ABC_DEF0, 1'b0);
    req(RD_LWU, 3'd0, 64'h8000_0020, 64'd0, 64'h0000_0000_9ABC_DEF0, 1'b0);
    check("lwu_cmd_is_lw", {61'h0, last_rd}, {61'h0, RD_LW});

    // SB into the upper lane of halfword 0x1234
    m_beats = 2;
    c0 = n_cmd;
    req(3'd0, WR_SB, 64'h8000_0001, 64'h0000_0000_0000_005A, 64'd0, 1'b0);
    check("sb_cmds", 64'(n_cmd - c0), RMW ? 64'd2 : 64'd1);
    check("sb_mem", {48'h0, mem[8'h01], mem[8'h00]}, RMW ? 64'h5A34 : 64'h5A5A);
    req(RD_LHU, 3'd0, 64'h8000_0000, 64'd0, RMW ? 64'h5A34 : 64'h5A5A, 1'b0);
    req(3'd0, WR_SH, 64'h8000_0006, 64'h0000_0000_0000_BEEF, 64'd0, 1'b0);
    req(RD_LH, 3'd0, 64'h8000_0006, 64'd0, 64'hFFFF_FFFF_FFFF_BEEF, 1'b0);

    // error paths: no DRAM access, response the cycle after accept
    c0 = n_cmd;
    req(RD_LW, 3'd0, 64'h8000_0002, 64'd0, 64'd0, 1'b1);
    check("misalign_latency", 64'(t_resp - t_drive + 1), 64'd2);
    req(RD_LD, 3'd0, 64'h0000_0010, 64'd0, 64'd0, 1'b1);
    check("range_latency", 64'(t_resp - t_drive + 1), 64'd2);
    req(RD_LD, WR_SD, 64'h8000_0010, 64'd0, 64'd0, 1'b1);
    req(3'd0, WR_SB, 64'h7FFF_FFFF, 64'h11, 64'd0, 1'b1);
    check("err_no_cmd", 64'(n_cmd - c0), 64'd0);

    // valid with no operation is ignored
    @(negedge clk);
    bus.req_valid = 1'b1;
    @(negedge clk);
    bus.req_valid = 1'b0;
    check("ignore_busy", {63'h0, bus.busy}, 64'd0);
    check("ignore_ready", {63'h0, bus.req_ready}, 64'd1);

    // controller stuck busy: timeout after 64 WAIT cycles, then accept again
    m_beats = 200;
    req(RD_LD, 3'd0, 64'h8000_0010, 64'd0, 64'd0, 1'b1);
    check("timeout_cycles", 64'(t_resp - t_cmd), 64'd65);
    m_beats = 2;
    req(RD_LD, 3'd0, 64'h8000_0010, 64'd0, 64'h1122_3344_5566_7788, 1'b0);

    // reset during WAIT aborts silently
    m_beats = 6;
    c0 = n_cmd; r0 = n_resp;
    do_req(RD_LD, 3'd0, 64'h8000_0010, 64'd0, 64'd0, 1'b0, 1'b0);
    guard = 0;
    while (n_cmd == c0 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    check("abort_cmd_seen", 64'(n_cmd - c0), 64'd1);
    @(negedge clk);
    check("abort_in_wait_busy", {63'h0, bus.busy}, 64'd1);
    rst_n = 1'b0;
    #1;
    check("abort_busy", {63'h0, bus.busy}, 64'd0);
    check("abort_ready", {63'h0, bus.req_ready}, 64'd1);
    check("abort_dm_addr", dm_addr, 64'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check("abort_no_resp", 64'(n_resp - r0), 64'd0);
    req(RD_LD, 3'd0, 64'h8000_0010, 64'd0, 64'h1122_3344_5566_7788, 1'b0);

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
